// File: rtl/dc_reset_pkg.sv
// Shared encodings and default 74.25 MHz timing for the Dreamcast reset controller.
package dc_reset_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } dc_state_e;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_I2C   = 2'd1,
        SRC_COMBO = 2'd2,
        SRC_FORCE = 2'd3
    } dc_source_e;

    localparam int unsigned DEF_ASSERT_CYCLES     = 7_425_000;
    localparam int unsigned DEF_COOLDOWN_CYCLES   = 74_250_000;
    localparam int unsigned DEF_COMBO_HOLD_CYCLES = 148_500_000;
    localparam logic [15:0] DEF_COMBO_MASK        = 16'h0E08;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dc_reset_combo_detect.sv
// Controller button-combo detector: one request pulse per continuous hold of the
// full combo; the combo must be released before it can request again.
module dc_reset_combo_detect #(
    parameter logic [15:0] COMBO_MASK        = 16'h0E08,
    parameter int unsigned COMBO_HOLD_CYCLES = 148_500_000
) (
    input  logic        hdmi_clock,
    input  logic        reset_clock,
    input  logic [15:0] buttons,
    output logic        combo_req
);

    localparam logic [31:0] HOLD_LAST = 32'(COMBO_HOLD_CYCLES - 1);

    logic        pressed;
    logic [31:0] hold_q, hold_d;
    logic        armed_q, armed_d;

    // An empty mask would otherwise read as "always pressed".
    assign pressed   = (COMBO_MASK != 16'h0000) && ((buttons & COMBO_MASK) == COMBO_MASK);
    assign combo_req = pressed && armed_q && (hold_q == HOLD_LAST);

    always_comb begin
        hold_d  = hold_q;
        armed_d = armed_q;
        if (!pressed) begin
            hold_d  = 32'd0;
            armed_d = 1'b1;
        end else begin
            // Saturate so a very long hold cannot wrap round to the trigger value.
            if (hold_q != HOLD_LAST) begin
                hold_d = hold_q + 32'd1;
            end
            if (combo_req) begin
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge hdmi_clock or posedge reset_clock) begin
        if (reset_clock) begin
            hold_q  <= 32'd0;
            armed_q <= 1'b1;
        end else begin
            hold_q  <= hold_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/dc_reset_controller.sv
// Arbitrates i2c / combo / force reset requests and drives one timed DC_NRESET
// low pulse followed by a cooldown, reporting the source and dropped requests.
module dc_reset_controller
    import dc_reset_pkg::*;
#(
    parameter int unsigned ASSERT_CYCLES     = DEF_ASSERT_CYCLES,
    parameter int unsigned COOLDOWN_CYCLES   = DEF_COOLDOWN_CYCLES,
    parameter int unsigned COMBO_HOLD_CYCLES = DEF_COMBO_HOLD_CYCLES,
    parameter logic [15:0] COMBO_MASK        = DEF_COMBO_MASK
) (
    input  logic        hdmi_clock,
    input  logic        reset_clock,
    input  logic        enable,
    input  logic        req_i2c,
    input  logic        req_force,
    input  logic [15:0] buttons,
    output logic        dc_nreset_drive,
    output logic        busy,
    output logic [1:0]  state,
    output logic [1:0]  source,
    output logic [7:0]  reset_count,
    output logic        req_dropped
);

    localparam logic [31:0] ASSERT_LAST   = 32'(ASSERT_CYCLES - 1);
    localparam logic [31:0] COOLDOWN_LAST = 32'(COOLDOWN_CYCLES - 1);

    logic        combo_req;
    logic        soft_req;
    logic        accept;
    dc_source_e  accept_src;

    dc_state_e   state_q, state_d;
    dc_source_e  source_q, source_d;
    logic [31:0] cnt_q, cnt_d;
    logic        force_pend_q, force_pend_d;
    logic [7:0]  count_q, count_d;
    logic        drop_q, drop_d;
    logic        drive_q, drive_d;
    logic        busy_q, busy_d;

    dc_reset_combo_detect #(
        .COMBO_MASK        (COMBO_MASK),
        .COMBO_HOLD_CYCLES (COMBO_HOLD_CYCLES)
    ) u_combo (
        .hdmi_clock  (hdmi_clock),
        .reset_clock (reset_clock),
        .buttons     (buttons),
        .combo_req   (combo_req)
    );

    assign soft_req = req_i2c | combo_req;

    always_comb begin
        state_d      = state_q;
        source_d     = source_q;
        cnt_d        = cnt_q;
        force_pend_d = force_pend_q;
        count_d      = count_q;
        drop_d       = 1'b0;
        accept       = 1'b0;
        accept_src   = SRC_NONE;

        case (state_q)
            ST_IDLE: begin
                // A soft request losing to force counts as served, not dropped.
                if (req_force || force_pend_q) begin
                    accept     = 1'b1;
                    accept_src = SRC_FORCE;
                end else if (soft_req) begin
                    if (enable) begin
                        accept     = 1'b1;
                        accept_src = req_i2c ? SRC_I2C : SRC_COMBO;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            ST_ASSERT: begin
                drop_d = soft_req;
                // Counter parks on its last value while force keeps the line low.
                if (cnt_q == ASSERT_LAST) begin
                    if (!req_force) begin
                        state_d = ST_COOLDOWN;
                        cnt_d   = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_COOLDOWN: begin
                drop_d = soft_req;
                if (req_force) begin
                    force_pend_d = 1'b1;
                end
                if (cnt_q == COOLDOWN_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        if (accept) begin
            state_d      = ST_ASSERT;
            cnt_d        = 32'd0;
            force_pend_d = 1'b0;
            source_d     = accept_src;
            count_d      = sat_inc8(count_q);
        end

        drive_d = (state_d == ST_ASSERT);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge hdmi_clock or posedge reset_clock) begin
        if (reset_clock) begin
            state_q      <= ST_IDLE;
            source_q     <= SRC_NONE;
            cnt_q        <= 32'd0;
            force_pend_q <= 1'b0;
            count_q      <= 8'd0;
            drop_q       <= 1'b0;
            drive_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            source_q     <= source_d;
            cnt_q        <= cnt_d;
            force_pend_q <= force_pend_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
            drive_q      <= drive_d;
            busy_q       <= busy_d;
        end
    end

    assign dc_nreset_drive = drive_q;
    assign busy            = busy_q;
    assign state           = state_q;
    assign source          = source_q;
    assign reset_count     = count_q;
    assign req_dropped     = drop_q;

endmodule

// File: tb/tb_dc_reset_controller.sv
// Directed self-checking bench for dc_reset_controller with short timing constants.
module tb_dc_reset_controller;

    localparam int unsigned A_CYC = 10;
    localparam int unsigned C_CYC = 20;
    localparam int unsigned H_CYC = 5;

    logic        hdmi_clock = 1'b0;
    logic        reset_clock;
    logic        enable;
    logic        req_i2c;
    logic        req_force;
    logic [15:0] buttons;
    logic        dc_nreset_drive;
    logic        busy;
    logic [1:0]  state;
    logic [1:0]  source;
    logic [7:0]  reset_count;
    logic        req_dropped;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dc_reset_controller #(
        .ASSERT_CYCLES     (A_CYC),
        .COOLDOWN_CYCLES   (C_CYC),
        .COMBO_HOLD_CYCLES (H_CYC),
        .COMBO_MASK        (16'h0003)
    ) dut (
        .hdmi_clock      (hdmi_clock),
        .reset_clock     (reset_clock),
        .enable          (enable),
        .req_i2c         (req_i2c),
        .req_force       (req_force),
        .buttons         (buttons),
        .dc_nreset_drive (dc_nreset_drive),
        .busy            (busy),
        .state           (state),
        .source          (source),
        .reset_count     (reset_count),
        .req_dropped     (req_dropped)
    );

    always #5 hdmi_clock = ~hdmi_clock;

    // Each step lands 1 ns after a rising edge: inputs change and outputs are sampled there.
    task automatic step();
        @(posedge hdmi_clock);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (state !== 2'd0 && n < budget) begin
            step();
            n++;
        end
        total_cnt++;
        if (state !== 2'd0) $display("FAIL wait_idle: state=%0d required 0 within %0d cycles", state, budget);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_clock = 1'b1; enable = 1'b1; req_i2c = 1'b0; req_force = 1'b0; buttons = 16'h0;
        repeat (3) step();
        total_cnt++; if (state !== 2'd0) $display("FAIL reset_state: got %0d required 0", state); else pass_cnt++;
        total_cnt++; if (dc_nreset_drive !== 1'b0) $display("FAIL reset_drive: got %b required 0", dc_nreset_drive); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (source !== 2'd0) $display("FAIL reset_source: got %0d required 0", source); else pass_cnt++;
        total_cnt++; if (reset_count !== 8'd0) $display("FAIL reset_count: got %0d required 0", reset_count); else pass_cnt++;
        total_cnt++; if (req_dropped !== 1'b0) $display("FAIL reset_dropped: got %b required 0", req_dropped); else pass_cnt++;
        reset_clock = 1'b0;
        step();
        $display("reset: state=%0d drive=%b count=%0d", state, dc_nreset_drive, reset_count);
    endtask

    task automatic test_i2c();
        int hi = 0;
        req_i2c = 1'b1;
        step();
        req_i2c = 1'b0;
        total_cnt++; if (dc_nreset_drive !== 1'b1 || state !== 2'd1) $display("FAIL i2c_start: drive=%b state=%0d required 1/1", dc_nreset_drive, state); else pass_cnt++;
        total_cnt++; if (source !== 2'd1) $display("FAIL i2c_source: got %0d required 1", source); else pass_cnt++;
        total_cnt++; if (reset_count !== 8'd1) $display("FAIL i2c_count: got %0d required 1", reset_count); else pass_cnt++;
        hi = 1;
        repeat (A_CYC - 1) begin
            step();
            if (dc_nreset_drive === 1'b1) hi++;
        end
        total_cnt++; if (hi != A_CYC) $display("FAIL i2c_low_time: got %0d required %0d", hi, A_CYC); else pass_cnt++;
        step();
        total_cnt++; if (state !== 2'd2 || dc_nreset_drive !== 1'b0 || busy !== 1'b1) $display("FAIL i2c_cooldown_entry: state=%0d drive=%b busy=%b required 2/0/1", state, dc_nreset_drive, busy); else pass_cnt++;
        repeat (C_CYC - 1) step();
        total_cnt++; if (state !== 2'd2) $display("FAIL i2c_cooldown_last: state=%0d required 2", state); else pass_cnt++;
        step();
        total_cnt++; if (state !== 2'd0 || busy !== 1'b0) $display("FAIL i2c_idle: state=%0d busy=%b required 0/0", state, busy); else pass_cnt++;
        $display("i2c reset: source=%0d count=%0d", source, reset_count);
    endtask

    task automatic test_combo();
        int rises = 0;
        logic prev = 1'b0;
        buttons = 16'h0003;
        for (int cyc = 1; cyc < 50; cyc++) begin
            step();
            if (dc_nreset_drive === 1'b1 && !prev) rises++;
            prev = dc_nreset_drive;
            if (cyc == 4) begin
                total_cnt++; if (dc_nreset_drive !== 1'b0) $display("FAIL combo_early: drive=%b required 0 at cycle 4", dc_nreset_drive); else pass_cnt++;
            end
            if (cyc == 5) begin
                total_cnt++; if (dc_nreset_drive !== 1'b1 || source !== 2'd2) $display("FAIL combo_start: drive=%b source=%0d required 1/2", dc_nreset_drive, source); else pass_cnt++;
            end
        end
        total_cnt++; if (rises != 1) $display("FAIL combo_single: rises=%0d required 1", rises); else pass_cnt++;
        total_cnt++; if (reset_count !== 8'd2) $display("FAIL combo_count: got %0d required 2", reset_count); else pass_cnt++;
        step();
        buttons = 16'h0000;
        step();
        buttons = 16'h0003;
        repeat (4) step();
        total_cnt++; if (dc_nreset_drive !== 1'b0) $display("FAIL combo_rehold_early: drive=%b required 0", dc_nreset_drive); else pass_cnt++;
        step();
        total_cnt++; if (dc_nreset_drive !== 1'b1 || reset_count !== 8'd3) $display("FAIL combo_rehold: drive=%b count=%0d required 1/3", dc_nreset_drive, reset_count); else pass_cnt++;
        buttons = 16'h0000;
        wait_idle(100);
        $display("combo reset: source=%0d count=%0d", source, reset_count);
    endtask

    task automatic test_force();
        int hi = 0;
        req_force = 1'b1;
        for (int cyc = 1; cyc <= 31; cyc++) begin
            step();
            if (cyc == 31) req_force = 1'b0;
            if (dc_nreset_drive === 1'b1) hi++;
            if (cyc == 1) begin
                total_cnt++; if (source !== 2'd3) $display("FAIL force_source: got %0d required 3", source); else pass_cnt++;
            end
        end
        total_cnt++; if (hi != 31) $display("FAIL force_low_time: got %0d required 31", hi); else pass_cnt++;
        step();
        total_cnt++; if (state !== 2'd2 || dc_nreset_drive !== 1'b0) $display("FAIL force_release: state=%0d drive=%b required 2/0", state, dc_nreset_drive); else pass_cnt++;
        wait_idle(100);
        $display("force reset: source=%0d count=%0d", source, reset_count);
    endtask

    task automatic test_simultaneous();
        int n = 0;
        req_i2c = 1'b1; req_force = 1'b1;
        step();
        req_i2c = 1'b0; req_force = 1'b0;
        total_cnt++; if (source !== 2'd3 || req_dropped !== 1'b0) $display("FAIL simul_winner: source=%0d dropped=%b required 3/0", source, req_dropped); else pass_cnt++;
        while (state !== 2'd2 && n < 50) begin step(); n++; end
        req_i2c = 1'b1;
        step();
        req_i2c = 1'b0;
        total_cnt++; if (req_dropped !== 1'b1) $display("FAIL cooldown_drop: got %b required 1", req_dropped); else pass_cnt++;
        step();
        total_cnt++; if (req_dropped !== 1'b0) $display("FAIL cooldown_drop_pulse: got %b required 0", req_dropped); else pass_cnt++;
        wait_idle(100);
        step();
        total_cnt++; if (state !== 2'd0 || reset_count !== 8'd5) $display("FAIL cooldown_no_reassert: state=%0d count=%0d required 0/5", state, reset_count); else pass_cnt++;
        $display("simultaneous: source=%0d count=%0d", source, reset_count);
    endtask

    task automatic test_force_pending();
        int n = 0;
        req_i2c = 1'b1;
        step();
        req_i2c = 1'b0;
        while (state !== 2'd2 && n < 50) begin step(); n++; end
        req_force = 1'b1;
        step();
        req_force = 1'b0;
        n = 0;
        while (state === 2'd2 && n < 50) begin step(); n++; end
        total_cnt++; if (state !== 2'd0) $display("FAIL pend_idle: state=%0d required 0", state); else pass_cnt++;
        step();
        total_cnt++; if (state !== 2'd1 || source !== 2'd3 || reset_count !== 8'd7) $display("FAIL pend_taken: state=%0d source=%0d count=%0d required 1/3/7", state, source, reset_count); else pass_cnt++;
        wait_idle(100);
        $display("pending force: source=%0d count=%0d", source, reset_count);
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        req_i2c = 1'b1;
        step();
        req_i2c = 1'b0;
        total_cnt++; if (req_dropped !== 1'b1 || state !== 2'd0) $display("FAIL disabled_drop: dropped=%b state=%0d required 1/0", req_dropped, state); else pass_cnt++;
        step();
        total_cnt++; if (req_dropped !== 1'b0 || reset_count !== 8'd7) $display("FAIL disabled_after: dropped=%b count=%0d required 0/7", req_dropped, reset_count); else pass_cnt++;
        enable = 1'b1;
        $display("disabled request: dropped and ignored");
    endtask

    task automatic test_reset_mid_assert();
        req_i2c = 1'b1;
        step();
        req_i2c = 1'b0;
        step(); step();
        #2 reset_clock = 1'b1;
        #1;
        total_cnt++; if (dc_nreset_drive !== 1'b0 || state !== 2'd0 || busy !== 1'b0) $display("FAIL midreset_release: drive=%b state=%0d busy=%b required 0/0/0", dc_nreset_drive, state, busy); else pass_cnt++;
        total_cnt++; if (reset_count !== 8'd0 || source !== 2'd0) $display("FAIL midreset_regs: count=%0d source=%0d required 0/0", reset_count, source); else pass_cnt++;
        step();
        reset_clock = 1'b0;
        step();
        req_i2c = 1'b1;
        step();
        req_i2c = 1'b0;
        total_cnt++; if (dc_nreset_drive !== 1'b1 || source !== 2'd1 || reset_count !== 8'd1) $display("FAIL midreset_next: drive=%b source=%0d count=%0d required 1/1/1", dc_nreset_drive, source, reset_count); else pass_cnt++;
        wait_idle(100);
        $display("reset mid-assert: count=%0d", reset_count);
    endtask

    task automatic test_saturation();
        repeat (260) begin
            req_i2c = 1'b1;
            step();
            req_i2c = 1'b0;
            wait_idle(100);
        end
        total_cnt++; if (reset_count !== 8'd255) $display("FAIL count_saturate: got %0d required 255", reset_count); else pass_cnt++;
        $display("saturation: count=%0d", reset_count);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i2c();
        test_combo();
        test_force();
        test_simultaneous();
        test_force_pending();
        test_enable_drop();
        test_reset_mid_assert();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
